// File: rtl/demux_1to2_dataflow_pkg.sv
// Shared types and helpers for the registered 1-to-2 data demultiplexer.
package demux_1to2_dataflow_pkg;

  localparam int DEMUX_WIDTH_DEFAULT = 8;

  // Destination chosen by sel.
  typedef enum logic {
    ROUTE_O0 = 1'b0,
    ROUTE_O1 = 1'b1
  } route_e;

  // One-hot destination enable {o1, o0}; all-zero when no valid transfer.
  function automatic logic [1:0] dest_onehot(input logic vld, input route_e route);
    dest_onehot = {vld & (route == ROUTE_O1), vld & (route == ROUTE_O0)};
  endfunction

endpackage

// File: rtl/demux_1to2_dataflow_if.sv
// Bus bundle between the producer and the demux. The producer (master)
// drives the word/select/valid; the demux (slave) drives both destinations.
interface demux_1to2_dataflow_if
  import demux_1to2_dataflow_pkg::*;
#(
  parameter int width = DEMUX_WIDTH_DEFAULT
);
  logic [width-1:0] i;
  logic             sel;
  logic             i_valid;
  logic [width-1:0] o0;
  logic [width-1:0] o1;
  logic             o0_valid;
  logic             o1_valid;

  modport master (
    output i, sel, i_valid,
    input  o0, o1, o0_valid, o1_valid
  );

  modport slave (
    input  i, sel, i_valid,
    output o0, o1, o0_valid, o1_valid
  );
endinterface

// File: rtl/demux_1to2_dataflow.sv
// Registered 1-to-2 demux. One cycle of latency, every output straight from
// a flop; the non-selected destination and idle cycles read as zero so no
// stale word ever lingers downstream.
module demux_1to2_dataflow
  import demux_1to2_dataflow_pkg::*;
#(
  parameter int width = DEMUX_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_1to2_dataflow_if.slave  bus
);

  logic [1:0]       en;
  logic [width-1:0] o0_d, o1_d;
  logic [width-1:0] o0_q, o1_q;
  logic [1:0]       vld_q;

  // Steering: pick a destination and zero the other one.
  always_comb begin
    en   = dest_onehot(bus.i_valid, route_e'(bus.sel));
    o0_d = en[0] ? bus.i : '0;
    o1_d = en[1] ? bus.i : '0;
  end

  // Output registers; reset discards any in-flight word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o0_q  <= '0;
      o1_q  <= '0;
      vld_q <= '0;
    end else begin
      o0_q  <= o0_d;
      o1_q  <= o1_d;
      vld_q <= en;
    end
  end

  assign bus.o0       = o0_q;
  assign bus.o1       = o1_q;
  assign bus.o0_valid = vld_q[0];
  assign bus.o1_valid = vld_q[1];

endmodule

// File: tb/tb_demux_1to2_dataflow.sv
// Directed bench for demux_1to2_dataflow (width 8). A reference model records
// which destination (if any) owns the last accepted word; a compare process
// checks every negedge against it, and the directed sequence pins literal
// expectations from the hand-worked test plan.
module tb_demux_1to2_dataflow;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  demux_1to2_dataflow_if #(.width(W)) bus ();

  demux_1to2_dataflow #(.width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: destination 0, 1, or 2 (= nobody) plus the word it holds.
  int         m_dest = 2;
  logic [W-1:0] m_word = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dest = 2;
    end else begin
      m_dest = bus.i_valid ? int'(bus.sel) : 2;
      m_word = bus.i;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Every-cycle comparison against the reference model.
  always @(negedge clk) begin
    chk("model_o0", bus.o0, (m_dest == 0) ? m_word : '0);
    chk("model_o1", bus.o1, (m_dest == 1) ? m_word : '0);
    chk("model_vld", {6'b0, bus.o1_valid, bus.o0_valid},
        {6'b0, m_dest == 1, m_dest == 0});
    chk("mutex", {7'b0, bus.o0_valid & bus.o1_valid}, '0);
  end

  task automatic chk_out(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic ev0, input logic ev1);
    chk({tag, "_o0"}, bus.o0, e0);
    chk({tag, "_o1"}, bus.o1, e1);
    chk({tag, "_vld"}, {6'b0, bus.o1_valid, bus.o0_valid}, {6'b0, ev1, ev0});
  endtask

  // At the next negedge: check outputs produced by the previous row, then
  // drive this row's inputs for the following edge.
  task automatic step(input logic v, input logic s, input logic [W-1:0] d,
                      input logic [W-1:0] e0, input logic [W-1:0] e1,
                      input logic ev0, input logic ev1, input string tag);
    @(negedge clk);
    chk_out(tag, e0, e1, ev0, ev1);
    bus.i_valid = v;
    bus.sel     = s;
    bus.i       = d;
  endtask

  initial begin
    bus.i = 8'hFF; bus.i_valid = 1'b1; bus.sel = 1'b0;
    // Reset asserted with live-looking inputs, no clock edge yet.
    #1 rst = 1'b1;
    #1 chk_out("rst_async", 8'h00, 8'h00, 1'b0, 1'b0);
    // Stays cleared across edges while held.
    @(negedge clk); chk_out("rst_hold1", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk); chk_out("rst_hold2", 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    bus.i_valid = 1'b1; bus.sel = 1'b0; bus.i = 8'hA0;

    //    v     s     i      exp o0 exp o1 v0    v1
    step(1'b1, 1'b0, 8'hB0, 8'hA0, 8'h00, 1'b1, 1'b0, "r0_a");
    step(1'b1, 1'b0, 8'hC0, 8'hB0, 8'h00, 1'b1, 1'b0, "r0_b");
    step(1'b1, 1'b0, 8'hD0, 8'hC0, 8'h00, 1'b1, 1'b0, "r0_c");
    step(1'b1, 1'b1, 8'hA0, 8'hD0, 8'h00, 1'b1, 1'b0, "r0_d");
    step(1'b1, 1'b1, 8'hB0, 8'h00, 8'hA0, 1'b0, 1'b1, "r1_a");
    step(1'b1, 1'b1, 8'hC0, 8'h00, 8'hB0, 1'b0, 1'b1, "r1_b");
    step(1'b1, 1'b1, 8'hD0, 8'h00, 8'hC0, 1'b0, 1'b1, "r1_c");
    step(1'b1, 1'b0, 8'h11, 8'h00, 8'hD0, 1'b0, 1'b1, "r1_d");
    step(1'b1, 1'b1, 8'h22, 8'h11, 8'h00, 1'b1, 1'b0, "alt_1");
    step(1'b1, 1'b0, 8'h33, 8'h00, 8'h22, 1'b0, 1'b1, "alt_2");
    step(1'b1, 1'b1, 8'h44, 8'h33, 8'h00, 1'b1, 1'b0, "alt_3");
    step(1'b0, 1'b1, 8'h5A, 8'h00, 8'h44, 1'b0, 1'b1, "alt_4");
    step(1'b1, 1'b1, 8'hC0, 8'h00, 8'h00, 1'b0, 1'b0, "idle");
    step(1'b1, 1'b0, 8'hD0, 8'h00, 8'hC0, 1'b0, 1'b1, "pre_rst");

    // Reset between edges while o1 holds C0 (its D0 capture is discarded).
    #1 rst = 1'b1;
    #1 chk_out("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk); chk_out("rst_mid_hold", 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1 chk_out("rel_zero", 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'hD0, 8'h00, 1'b1, 1'b0, "post_rst");
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "post_idle");

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
